// File: rtl/shift_chain.sv
// Parametrised scan/shift chain: parallel load, manual single-step shift and an
// automatic WIDTH-step shift-out run with start/busy/done handshake.
module shift_chain #(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RST_VAL   = {WIDTH{1'b1}},
   parameter bit                MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] par_in,
   input  logic             load,
   input  logic             shift,
   input  logic             s_in,
   input  logic             start,
   output logic [WIDTH-1:0] par_out,
   output logic             s_out,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   reg_q, reg_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   shifted;

   // Register contents after one shift step in the configured direction.
   generate
      if (WIDTH == 1) begin : g_w1
         assign shifted = s_in;
      end else if (MSB_FIRST) begin : g_msb
         assign shifted = {reg_q[WIDTH-2:0], s_in};
      end else begin : g_lsb
         assign shifted = {s_in, reg_q[WIDTH-1:1]};
      end
   endgenerate

   // Serial output is the bit that leaves on the next shift edge.
   generate
      if (MSB_FIRST) begin : g_sout_msb
         assign s_out = reg_q[WIDTH-1];
      end else begin : g_sout_lsb
         assign s_out = reg_q[0];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
         reg_q   <= RST_VAL;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         reg_q   <= reg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // IDLE: load > start > shift > hold. RUN ignores all requests until the last step.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      reg_d   = reg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               reg_d = par_in;
            end else if (start) begin
               state_d = RUN;
               count_d = CNT_W'(WIDTH);
               busy_d  = 1'b1;
            end else if (shift) begin
               reg_d = shifted;
            end
         end
         RUN: begin
            reg_d   = shifted;
            count_d = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign par_out = reg_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_shift_chain.sv
// Bench for shift_chain: two 8-bit instances (MSB-first and LSB-first) sharing
// stimulus, checked against an arithmetic reference model.
module tb_shift_chain;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] par_in = 8'h00;
   logic       load = 1'b0, shift = 1'b0, s_in = 1'b0, start = 1'b0;

   logic [7:0] par_a, par_b;
   logic       sout_a, sout_b, busy_a, busy_b, done_a, done_b;

   int checks = 0;
   int failures = 0;

   // Reference model state
   int m_a, m_b, m_left;
   bit m_done;

   always #5 clk = ~clk;

   shift_chain #(.WIDTH(8), .RST_VAL(8'hFF), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .par_in(par_in), .load(load), .shift(shift),
      .s_in(s_in), .start(start), .par_out(par_a), .s_out(sout_a),
      .busy(busy_a), .done(done_a));

   shift_chain #(.WIDTH(8), .RST_VAL(8'hFF), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .par_in(par_in), .load(load), .shift(shift),
      .s_in(s_in), .start(start), .par_out(par_b), .s_out(sout_b),
      .busy(busy_b), .done(done_b));

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int shl_in(input int r, input bit b);
      return (r * 2 + int'(b)) % 256;
   endfunction

   function automatic int shr_in(input int r, input bit b);
      return r / 2 + int'(b) * 128;
   endfunction

   task automatic model_reset();
      m_a = 255; m_b = 255; m_left = 0; m_done = 1'b0;
   endtask

   // One clock edge of the reference model, using the inputs present before the edge.
   task automatic model_edge(input bit ld, input int pi, input bit sh, input bit si, input bit st);
      if (m_left > 0) begin
         m_a = shl_in(m_a, si);
         m_b = shr_in(m_b, si);
         m_left--;
         m_done = (m_left == 0);
      end else begin
         m_done = 1'b0;
         if (ld) begin
            m_a = pi; m_b = pi;
         end else if (st) begin
            m_left = 8;
         end else if (sh) begin
            m_a = shl_in(m_a, si);
            m_b = shr_in(m_b, si);
         end
      end
   endtask

   task automatic check_model(input string ctx);
      chk_eq({ctx, ".par_a"},  32'(par_a),  32'(m_a));
      chk_eq({ctx, ".par_b"},  32'(par_b),  32'(m_b));
      chk_eq({ctx, ".sout_a"}, 32'(sout_a), 32'(m_a / 128));
      chk_eq({ctx, ".sout_b"}, 32'(sout_b), 32'(m_b % 2));
      chk_eq({ctx, ".busy_a"}, 32'(busy_a), 32'(m_left > 0));
      chk_eq({ctx, ".busy_b"}, 32'(busy_b), 32'(m_left > 0));
      chk_eq({ctx, ".done_a"}, 32'(done_a), 32'(m_done));
      chk_eq({ctx, ".done_b"}, 32'(done_b), 32'(m_done));
   endtask

   // Called at a negedge: drive inputs, take one edge, return at next negedge after checking.
   task automatic cyc(input string ctx, input bit ld, input logic [7:0] pi, input bit sh,
                      input bit si, input bit st);
      load = ld; par_in = pi; shift = sh; s_in = si; start = st;
      @(posedge clk);
      model_edge(ld, int'(pi), sh, si, st);
      @(negedge clk);
      load = 1'b0; shift = 1'b0; start = 1'b0;
      check_model(ctx);
   endtask

   // Called at a negedge: assert reset between edges and check it acts at once.
   task automatic mid_reset(input string ctx);
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk_eq({ctx, ".rst_par_a"}, 32'(par_a), 32'hFF);
      chk_eq({ctx, ".rst_sout_a"}, 32'(sout_a), 32'h1);
      check_model({ctx, ".rst"});
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic auto_run(input string ctx, input bit noise);
      logic [7:0] exp_s;
      exp_s = 8'hA5;
      cyc({ctx, ".load"}, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      cyc({ctx, ".start"}, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk_eq({ctx, ".busy_on"}, 32'(busy_a), 32'h1);
      for (int i = 0; i < 8; i++) begin
         chk_eq($sformatf("%s.sout%0d", ctx, i), 32'(sout_a), 32'(exp_s[7-i]));
         cyc($sformatf("%s.run%0d", ctx, i), noise, 8'h00, noise, 1'b1, noise);
         if (i < 7) chk_eq($sformatf("%s.busy%0d", ctx, i), 32'(busy_a), 32'h1);
      end
      chk_eq({ctx, ".final"}, 32'(par_a), 32'hFF);
      chk_eq({ctx, ".done"}, 32'(done_a), 32'h1);
      chk_eq({ctx, ".busy_off"}, 32'(busy_a), 32'h0);
      cyc({ctx, ".after"}, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_eq({ctx, ".done_clr"}, 32'(done_a), 32'h0);
   endtask

   initial begin
      logic [7:0] exp_sh;
      logic [7:0] exp_so;
      model_reset();

      // Reset asserted between edges with no edge needed
      @(negedge clk);
      mid_reset("reset");
      chk_eq("reset.busy", 32'(busy_a), 32'h0);

      // Load and three manual shifts in
      cyc("ld", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      chk_eq("ld.par", 32'(par_a), 32'hA5);
      chk_eq("ld.sout", 32'(sout_a), 32'h1);
      exp_sh = 8'h4A;
      exp_so = 8'h05;
      for (int i = 0; i < 3; i++) begin
         chk_eq($sformatf("man.sout%0d", i), 32'(sout_a), 32'(exp_so[2-i]));
         cyc($sformatf("man%0d", i), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         chk_eq($sformatf("man.par%0d", i), 32'(par_a), 32'(exp_sh));
         exp_sh = (i == 0) ? 8'h94 : 8'h28;
      end

      // Automatic run, clean and with ignored requests during RUN
      auto_run("auto", 1'b0);
      auto_run("noisy", 1'b1);

      // Load beats start in IDLE
      cyc("ldst", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b1);
      chk_eq("ldst.par", 32'(par_a), 32'h3C);
      chk_eq("ldst.busy", 32'(busy_a), 32'h0);
      cyc("ldst2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_eq("ldst.done", 32'(done_a), 32'h0);

      // Abort a run after the third shift
      cyc("ab.ld", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      cyc("ab.st", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) cyc($sformatf("ab.run%0d", i), 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      mid_reset("abort");
      chk_eq("abort.busy", 32'(busy_a), 32'h0);
      for (int i = 0; i < 6; i++) begin
         cyc($sformatf("ab.idle%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         chk_eq($sformatf("ab.nodone%0d", i), 32'(done_a), 32'h0);
      end

      // LSB-first run from 0F with s_in low
      cyc("lsb.ld", 1'b1, 8'h0F, 1'b0, 1'b0, 1'b0);
      cyc("lsb.st", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      exp_so = 8'h0F;
      for (int i = 0; i < 8; i++) begin
         chk_eq($sformatf("lsb.sout%0d", i), 32'(sout_b), 32'(exp_so[i]));
         cyc($sformatf("lsb.run%0d", i), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      end
      chk_eq("lsb.final", 32'(par_b), 32'h00);
      chk_eq("lsb.done", 32'(done_b), 32'h1);

      // Restart in the done cycle
      cyc("re.st", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
      chk_eq("re.busy", 32'(busy_a), 32'h1);

      // Randomised traffic with occasional mid-cycle reset
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 79) == 0) begin
            mid_reset($sformatf("rnd.rst%0d", n));
         end else begin
            cyc($sformatf("rnd%0d", n),
                ($urandom_range(0, 7) == 0), 8'($urandom),
                1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
